// File: rtl/lives_score_manager.sv
`default_nettype none
// ============================================================================
//  Module   : lives_score_manager
//  Purpose  : Turns per-frame hit pulses and collision levels into game state:
//             lives, saturating score, death/respawn timing, invulnerability
//             window and game over. Drives HUD digits, player freeze and the
//             smiley blink strobe.
//  Ports    : clk, resetN (async, active-low)
//             startOfFrame           - 1-cycle pulse per frame
//             start_game             - start/restart request level
//             SingleHitPulse         - first collision of the frame, 1 cycle
//                                      after its cause
//             collision_Smiley_Hart  - pellet overlap level
//             collision_smiley_ghost - ghost overlap level
//             lives, score, game_state, player_freeze, player_blink,
//             respawn_pulse, game_over
//  Revision : 1.0 - initial release
// ============================================================================
module lives_score_manager #(
   parameter int LIVES_INIT    = 3,
   parameter int LIVES_W       = 3,
   parameter int SCORE_W       = 16,
   parameter int PELLET_POINTS = 10,
   parameter int DEATH_FRAMES  = 45,
   parameter int INVULN_FRAMES = 60
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic               startOfFrame,
   input  logic               start_game,
   input  logic               SingleHitPulse,
   input  logic               collision_Smiley_Hart,
   input  logic               collision_smiley_ghost,
   output logic [LIVES_W-1:0] lives,
   output logic [SCORE_W-1:0] score,
   output logic [2:0]         game_state,
   output logic               player_freeze,
   output logic               player_blink,
   output logic               respawn_pulse,
   output logic               game_over
);

   // Counter is wide enough for either window and always has bit 2 for blink.
   localparam int c_CNT_MAX = (DEATH_FRAMES > INVULN_FRAMES) ? DEATH_FRAMES : INVULN_FRAMES;
   localparam int c_CNT_W   = ($clog2(c_CNT_MAX + 1) < 3) ? 3 : $clog2(c_CNT_MAX + 1);

   localparam logic [c_CNT_W-1:0] c_DEATH   = c_CNT_W'(DEATH_FRAMES);
   localparam logic [c_CNT_W-1:0] c_INVULN  = c_CNT_W'(INVULN_FRAMES);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
   localparam logic [LIVES_W-1:0] c_LIVES   = LIVES_W'(LIVES_INIT);
   localparam logic [LIVES_W-1:0] c_LIFE    = LIVES_W'(1);
   localparam logic [SCORE_W:0]   c_PELLET  = (SCORE_W + 1)'(PELLET_POINTS);
   localparam logic [SCORE_W-1:0] c_SCORE_MAX = {SCORE_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PLAY   = 3'd1,
      S_DYING  = 3'd2,
      S_INVULN = 3'd3,
      S_OVER   = 3'd4
   } state_t;

   state_t               r_state,     w_state_nxt;
   logic [LIVES_W-1:0]   r_lives,     w_lives_nxt;
   logic [SCORE_W-1:0]   r_score,     w_score_nxt;
   logic [c_CNT_W-1:0]   r_frame_cnt, w_cnt_nxt;
   logic                 r_respawn,   w_respawn_nxt;
   logic                 r_col_pel_d;
   logic                 r_col_gho_d;

   logic                 w_hit_pel;
   logic                 w_hit_gho;
   logic [SCORE_W:0]     w_score_sum;
   logic [SCORE_W-1:0]   w_score_sat;

   // SingleHitPulse arrives one cycle after the collision that caused it, so
   // the levels are delayed one stage to line up with it.
   assign w_hit_pel   = SingleHitPulse & r_col_pel_d;
   assign w_hit_gho   = SingleHitPulse & r_col_gho_d;

   // One extra bit catches the carry so the score clamps instead of wrapping.
   assign w_score_sum = {1'b0, r_score} + c_PELLET;
   assign w_score_sat = w_score_sum[SCORE_W] ? c_SCORE_MAX : w_score_sum[SCORE_W-1:0];

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state     <= S_IDLE;
         r_lives     <= c_LIVES;
         r_score     <= '0;
         r_frame_cnt <= '0;
         r_respawn   <= 1'b0;
         r_col_pel_d <= 1'b0;
         r_col_gho_d <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_lives     <= w_lives_nxt;
         r_score     <= w_score_nxt;
         r_frame_cnt <= w_cnt_nxt;
         r_respawn   <= w_respawn_nxt;
         r_col_pel_d <= collision_Smiley_Hart;
         r_col_gho_d <= collision_smiley_ghost;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_lives_nxt   = r_lives;
      w_score_nxt   = r_score;
      w_cnt_nxt     = r_frame_cnt;
      w_respawn_nxt = 1'b0;
      case (r_state)
         S_IDLE, S_OVER: begin
            if (start_game) begin
               w_state_nxt = S_PLAY;
               w_lives_nxt = c_LIVES;
               w_score_nxt = '0;
            end
         end
         S_PLAY: begin
            // Ghost wins over pellet when both are flagged on the same pulse.
            if (w_hit_gho) begin
               w_lives_nxt = r_lives - c_LIFE;
               if (r_lives == c_LIFE) begin
                  w_state_nxt = S_OVER;
               end else begin
                  w_state_nxt = S_DYING;
                  w_cnt_nxt   = c_DEATH;
               end
            end else if (w_hit_pel) begin
               w_score_nxt = w_score_sat;
            end
         end
         S_DYING: begin
            if (startOfFrame) begin
               if (r_frame_cnt == c_CNT_ONE) begin
                  w_state_nxt   = S_INVULN;
                  w_cnt_nxt     = c_INVULN;
                  w_respawn_nxt = 1'b1;
               end else begin
                  w_cnt_nxt = r_frame_cnt - c_CNT_ONE;
               end
            end
         end
         S_INVULN: begin
            if (w_hit_pel) begin
               w_score_nxt = w_score_sat;
            end
            if (startOfFrame) begin
               w_cnt_nxt = r_frame_cnt - c_CNT_ONE;
               if (r_frame_cnt == c_CNT_ONE) begin
                  w_state_nxt = S_PLAY;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign lives         = r_lives;
   assign score         = r_score;
   assign game_state    = r_state;
   assign respawn_pulse = r_respawn;
   assign game_over     = (r_state == S_OVER);
   assign player_freeze = (r_state == S_IDLE) | (r_state == S_DYING) | (r_state == S_OVER);
   assign player_blink  = (r_state == S_INVULN) & r_frame_cnt[2];

endmodule
`default_nettype wire

// File: tb/tb_lives_score_manager.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lives_score_manager
//  Purpose  : Self-checking bench for lives_score_manager. Directed scenarios
//             followed by random stimulus, every cycle compared against a
//             behavioural game model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lives_score_manager;

   localparam int LIVES_INIT    = 3;
   localparam int SCORE_W       = 16;
   localparam int PELLET_POINTS = 10;
   localparam int DEATH_FRAMES  = 45;
   localparam int INVULN_FRAMES = 60;
   localparam int SCORE_MAX     = 65535;

   localparam int M_IDLE = 0, M_PLAY = 1, M_DYING = 2, M_INVULN = 3, M_OVER = 4;

   logic        clk = 1'b0;
   logic        resetN;
   logic        startOfFrame, start_game, SingleHitPulse;
   logic        collision_Smiley_Hart, collision_smiley_ghost;
   logic [2:0]  lives;
   logic [15:0] score;
   logic [2:0]  game_state;
   logic        player_freeze, player_blink, respawn_pulse, game_over;

   int n_checks = 0;
   int n_errors = 0;

   // behavioural model state
   int m_mode, m_lives, m_score, m_cnt;
   bit m_resp, m_pel_prev, m_gho_prev;

   always #5 clk = ~clk;

   lives_score_manager dut (
      .clk                   (clk),
      .resetN                (resetN),
      .startOfFrame          (startOfFrame),
      .start_game            (start_game),
      .SingleHitPulse        (SingleHitPulse),
      .collision_Smiley_Hart (collision_Smiley_Hart),
      .collision_smiley_ghost(collision_smiley_ghost),
      .lives                 (lives),
      .score                 (score),
      .game_state            (game_state),
      .player_freeze         (player_freeze),
      .player_blink          (player_blink),
      .respawn_pulse         (respawn_pulse),
      .game_over             (game_over)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_lives = LIVES_INIT; m_score = 0; m_cnt = 0;
      m_resp = 0; m_pel_prev = 0; m_gho_prev = 0;
   endtask

   function automatic int add_points(int s);
      return (s + PELLET_POINTS > SCORE_MAX) ? SCORE_MAX : s + PELLET_POINTS;
   endfunction

   // One clock of game rules, applied to the inputs seen at the edge.
   task automatic model_update(bit sof, bit hit, bit sg, bit pel, bit gho);
      bit pel_hit, gho_hit;
      pel_hit = hit && m_pel_prev;
      gho_hit = hit && m_gho_prev;
      m_resp  = 0;
      case (m_mode)
         M_IDLE, M_OVER:
            if (sg) begin m_mode = M_PLAY; m_lives = LIVES_INIT; m_score = 0; end
         M_PLAY:
            if (gho_hit) begin
               m_lives = m_lives - 1;
               if (m_lives == 0) m_mode = M_OVER;
               else begin m_mode = M_DYING; m_cnt = DEATH_FRAMES; end
            end else if (pel_hit) m_score = add_points(m_score);
         M_DYING:
            if (sof) begin
               m_cnt = m_cnt - 1;
               if (m_cnt == 0) begin m_mode = M_INVULN; m_cnt = INVULN_FRAMES; m_resp = 1; end
            end
         M_INVULN: begin
            if (pel_hit) m_score = add_points(m_score);
            if (sof) begin
               m_cnt = m_cnt - 1;
               if (m_cnt == 0) m_mode = M_PLAY;
            end
         end
         default: ;
      endcase
      m_pel_prev = pel;
      m_gho_prev = gho;
   endtask

   task automatic compare_all();
      check("game_state",    32'(game_state),    32'(m_mode));
      check("lives",         32'(lives),         32'(m_lives));
      check("score",         32'(score),         32'(m_score));
      check("player_freeze", 32'(player_freeze),
            32'(m_mode == M_IDLE || m_mode == M_DYING || m_mode == M_OVER));
      check("player_blink",  32'(player_blink),  32'(m_mode == M_INVULN && ((m_cnt >> 2) & 1) == 1));
      check("respawn_pulse", 32'(respawn_pulse), 32'(m_resp));
      check("game_over",     32'(game_over),     32'(m_mode == M_OVER));
   endtask

   task automatic step(bit sof, bit hit, bit sg, bit pel, bit gho);
      startOfFrame           = sof;
      SingleHitPulse         = hit;
      start_game             = sg;
      collision_Smiley_Hart  = pel;
      collision_smiley_ghost = gho;
      @(posedge clk);
      model_update(sof, hit, sg, pel, gho);
      #1;
      compare_all();
   endtask

   // Ghost hit: level one cycle, pulse the next.
   task automatic ghost_hit();
      step(0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0);
   endtask

   // Run frames (with random ghost collisions) until the DUT reports target.
   task automatic run_until(input int target, input int bound);
      int n = 0;
      while (game_state != 3'(target) && n < bound) begin
         step(n % 2 == 0, $urandom_range(0, 2) == 0, 0, 0, $urandom_range(0, 1) == 1);
         n++;
      end
      check("wait_state", 32'(game_state), 32'(target));
   endtask

   initial begin
      resetN = 1'b0;
      startOfFrame = 0; start_game = 0; SingleHitPulse = 0;
      collision_Smiley_Hart = 0; collision_smiley_ghost = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      resetN = 1'b1;

      // start game
      step(0, 0, 1, 0, 0);
      check("t1_state", 32'(game_state), 32'(M_PLAY));
      check("t1_freeze", 32'(player_freeze), 32'd0);

      // three pellets, then levels without a pulse
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 1, 0);
         step(0, 1, 0, 0, 0);
      end
      check("t2_score", 32'(score), 32'd30);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0);
      check("t2_no_pulse", 32'(score), 32'd30);

      // death, respawn, invulnerability
      ghost_hit();
      check("t3_lives", 32'(lives), 32'd2);
      run_until(M_INVULN, 200);
      run_until(M_PLAY, 300);
      check("t3_lives_kept", 32'(lives), 32'd2);

      // pellet and ghost on the same pulse
      step(0, 0, 0, 1, 1);
      step(0, 1, 0, 0, 0);
      check("t4_lives", 32'(lives), 32'd1);
      check("t4_score", 32'(score), 32'd30);
      run_until(M_PLAY, 500);

      // last life -> game over, then restart
      ghost_hit();
      check("t6_over", 32'(game_over), 32'd1);
      check("t6_lives0", 32'(lives), 32'd0);
      step(0, 0, 1, 0, 0);
      check("t6_restart_lives", 32'(lives), 32'd3);

      // saturation: pellet level held, pulse every cycle
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 6560; i++) step(0, 1, 0, 1, 0);
      check("t5_saturate", 32'(score), 32'(SCORE_MAX));

      // async reset in the middle of DYING
      ghost_hit();
      step(1, 0, 0, 0, 0);
      #2;
      resetN = 1'b0;
      model_reset();
      #1;
      compare_all();
      check("t6_reset_state", 32'(game_state), 32'(M_IDLE));
      @(negedge clk);
      resetN = 1'b1;

      // random play
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 40) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 4) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
